pi_bus_ctl: RTL and testbench
=============================

Name: pi_bus_ctl

Overview:
- Sequences Pi-initiated RAM reads and writes into the Pi slot of the 16-cycle bus frame, using the slot strobes from the bus timing generator.
- Owns the RAM address mux, RAM control strobes and data-bus direction for both Pi and CPU slots.
- Presents a level request / one-cycle done handshake to the Pi-facing (SPI) side.

Parameters:
- ADDR_WIDTH, 17, RAM/bus address width.
- DATA_WIDTH, 8, data width.
- TIMEOUT, 40, clk16 cycles a latched request may wait for a pi_strobe rise before abort.

Ports:
- clk16  in  1  system clock, 16 MHz
- reset_n  in  1  synchronous, active-low reset
- pi_select  in  1  Pi slot window, from bus timing generator
- pi_strobe  in  1  Pi access strobe, from bus timing generator
- cpu_select  in  1  CPU slot window
- cpu_strobe  in  1  CPU access strobe
- pi_req  in  1  request level, Pi side
- pi_we  in  1  1 = write, 0 = read
- pi_addr  in  ADDR_WIDTH  request address
- pi_wr_data  in  DATA_WIDTH  write data
- pi_busy  out  1  request latched, not yet complete
- pi_done  out  1  one-cycle completion pulse
- pi_err  out  1  one-cycle timeout pulse
- pi_rd_data  out  DATA_WIDTH  read result, valid from pi_done until next pi_done
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_rw  in  1  CPU R/W (1 = read)
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_din  in  DATA_WIDTH  RAM read data
- ram_dout  out  DATA_WIDTH  RAM write data
- ram_dout_oe  out  1  controller drives the RAM data bus
- ram_we_n  out  1  RAM write enable, active-low
- ram_oe_n  out  1  RAM output enable, active-low

Behaviour:
- All outputs are registered except ram_addr, ram_we_n, ram_oe_n and ram_dout_oe, which are combinational from registered state and the slot inputs.
- Reset (reset_n = 0 at posedge clk16):
  - state = IDLE; pi_busy = pi_done = pi_err = 0.
  - pi_rd_data = 0; stall counter = 0.
  - Edge-detect registers cleared. Reset mid-transaction aborts it with no pi_done.
- Edge detect: strobe_rise = pi_strobe & ~pi_strobe_q; strobe_fall = ~pi_strobe & pi_strobe_q.
- IDLE:
  - If pi_req = 1, latch pi_we, pi_addr and pi_wr_data; pi_busy <= 1; go to WAIT_SLOT.
  - pi_req is ignored while pi_busy = 1.
- WAIT_SLOT:
  - Stall counter increments each cycle.
  - On strobe_rise, go to ACCESS. A request latched on the same cycle pi_strobe rises waits for the next frame.
  - If the counter reaches TIMEOUT-1 with no strobe_rise: pi_err pulse, pi_busy <= 0, go to IDLE.
- ACCESS (lasts the full pi_strobe high period):
  - On strobe_fall: if read, pi_rd_data <= ram_din (sampled on that cycle). Then pi_done pulse, pi_busy <= 0, go to IDLE.
- RAM mux:
  - pi_select = 1: ram_addr = latched address.
  - Otherwise: ram_addr = cpu_addr.
- Pi access strobes, state ACCESS with pi_strobe = 1:
  - Write: ram_we_n = 0, ram_dout_oe = 1, ram_dout = latched data.
  - Read: ram_oe_n = 0.
- CPU access strobes, cpu_strobe = 1:
  - cpu_rw = 0: ram_we_n = 0.
  - cpu_rw = 1: ram_oe_n = 0.
  - The CPU drives its own data; ram_dout_oe = 0.
- Defaults: outside the cases above, ram_we_n = ram_oe_n = 1 and ram_dout_oe = 0.
- Invariants:
  - ram_we_n and ram_oe_n are never both 0.
  - Simultaneous pi_select and cpu_select is illegal input; pi_select takes priority.
- pi_done and pi_err are mutually exclusive.
- Back-to-back transactions: pi_req held high after pi_done is re-latched on the next cycle. At most one transaction completes per 16-cycle frame.

Optional Feature:
- PI_ADDR_INC_EN defined:
  - A sampled pi_req with pi_addr all-ones (burst code) reuses the previous latched address + 1, wrapping modulo 2^ADDR_WIDTH.
  - Enables sequential bursts without resending the address.
- Not defined: pi_addr is always used verbatim; no increment logic.

Test Plan:
- Write: pi_req with we = 1, addr = 0x08000, data = 0xA5, asserted mid-frame.
  - ram_we_n low for exactly the 2 pi_strobe cycles, with ram_addr = 0x08000 and ram_dout = 0xA5.
  - One pi_done pulse; pi_busy falls on the same cycle.
- Read back: read of 0x08000 with the RAM model holding 0xA5.
  - ram_oe_n low during pi_strobe; pi_rd_data = 0xA5 on pi_done.
- Late request: pi_req latched on the same cycle pi_strobe rises.
  - Serviced in the following frame; pi_done 16 cycles later than an early request's.
- Timeout: pi_strobe held low permanently, pi_req = 1.
  - pi_err pulses after 40 cycles; pi_busy = 0; no RAM strobes.
- Reset: reset_n = 0 during ACCESS.
  - Next cycle all strobes inactive, pi_busy = 0, no pi_done.
  - Normal write succeeds after release.
- PI_ADDR_INC_EN: write 0x1FFFF with data 0x11, then a burst request.
  - Second write lands at 0x00000 (wrap).
  - With the macro undefined, it lands at 0x1FFFF.

Source files
------------

// File: rtl/pi_bus_ctl.sv
// Pi-side RAM access sequencer: places Pi reads/writes into the Pi slot of the bus frame and muxes RAM control.
// Optional build macro PI_ADDR_INC_EN: an all-ones pi_addr requests the previous latched address + 1.
module pi_bus_ctl #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 40
) (
    input  logic                  clk16,
    input  logic                  reset_n,
    input  logic                  pi_select,
    input  logic                  pi_strobe,
    input  logic                  cpu_select,
    input  logic                  cpu_strobe,
    input  logic                  pi_req,
    input  logic                  pi_we,
    input  logic [ADDR_WIDTH-1:0] pi_addr,
    input  logic [DATA_WIDTH-1:0] pi_wr_data,
    output logic                  pi_busy,
    output logic                  pi_done,
    output logic                  pi_err,
    output logic [DATA_WIDTH-1:0] pi_rd_data,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_rw,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_din,
    output logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  ram_dout_oe,
    output logic                  ram_we_n,
    output logic                  ram_oe_n
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_ACCESS    = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    pi_strobe_q_r;
    logic                    we_lat_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [CNT_W-1:0]        stall_cnt_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_r;
    logic [DATA_WIDTH-1:0]   rd_data_r;
    logic [ADDR_WIDTH-1:0]   addr_sel_s;

    logic strobe_rise_s;
    logic strobe_fall_s;
    logic latch_s;
    logic finish_s;
    logic abort_s;
    logic pi_access_s;
    logic cpu_access_s;

    assign strobe_rise_s = pi_strobe & ~pi_strobe_q_r;
    assign strobe_fall_s = ~pi_strobe & pi_strobe_q_r;
    assign latch_s       = (state_r == ST_IDLE) & pi_req;
    assign finish_s      = (state_r == ST_ACCESS) & strobe_fall_s;
    assign abort_s       = (state_r == ST_WAIT_SLOT) & ~strobe_rise_s & (stall_cnt_r == CNT_LAST);
    // The rise cycle itself belongs to the access so the RAM strobe spans the whole pi_strobe pulse.
    assign pi_access_s   = pi_strobe & ((state_r == ST_ACCESS) |
                                        ((state_r == ST_WAIT_SLOT) & strobe_rise_s));
    assign cpu_access_s  = cpu_strobe & cpu_select & ~pi_select;

    // Address captured on request: verbatim, or incremented for the burst code
    always_comb begin
        addr_sel_s = pi_addr;
`ifdef PI_ADDR_INC_EN
        if (&pi_addr) begin
            addr_sel_s = addr_r + ADDR_WIDTH'(1);
        end else begin
            addr_sel_s = pi_addr;
        end
`else
        addr_sel_s = pi_addr;
`endif
    end

    // State register
    always_ff @(posedge clk16) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pi_req) begin
                    state_nxt_s = ST_WAIT_SLOT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_SLOT: begin
                if (strobe_rise_s) begin
                    state_nxt_s = ST_ACCESS;
                end else if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_SLOT;
                end
            end
            ST_ACCESS: begin
                if (strobe_fall_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Request latch, stall counter, handshake pulses and read capture
    always_ff @(posedge clk16) begin
        if (!reset_n) begin
            pi_strobe_q_r <= 1'b0;
            we_lat_r      <= 1'b0;
            addr_r        <= '0;
            wdata_r       <= '0;
            stall_cnt_r   <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            rd_data_r     <= '0;
        end else begin
            pi_strobe_q_r <= pi_strobe;
            done_r        <= finish_s;
            err_r         <= abort_s;
            if (latch_s) begin
                we_lat_r    <= pi_we;
                addr_r      <= addr_sel_s;
                wdata_r     <= pi_wr_data;
                stall_cnt_r <= '0;
                busy_r      <= 1'b1;
            end else if (finish_s || abort_s) begin
                busy_r      <= 1'b0;
            end else if (state_r == ST_WAIT_SLOT) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (finish_s && !we_lat_r) begin
                rd_data_r <= ram_din;
            end
        end
    end

    // RAM address mux and control strobes for both slots
    always_comb begin
        ram_addr    = cpu_addr;
        ram_we_n    = 1'b1;
        ram_oe_n    = 1'b1;
        ram_dout_oe = 1'b0;
        if (pi_select) begin
            ram_addr = addr_r;
        end else begin
            ram_addr = cpu_addr;
        end
        if (pi_access_s) begin
            if (we_lat_r) begin
                ram_we_n    = 1'b0;
                ram_dout_oe = 1'b1;
            end else begin
                ram_oe_n    = 1'b0;
            end
        end else if (cpu_access_s) begin
            if (cpu_rw) begin
                ram_oe_n = 1'b0;
            end else begin
                ram_we_n = 1'b0;
            end
        end else begin
            ram_we_n    = 1'b1;
            ram_oe_n    = 1'b1;
            ram_dout_oe = 1'b0;
        end
    end

    assign pi_busy    = busy_r;
    assign pi_done    = done_r;
    assign pi_err     = err_r;
    assign pi_rd_data = rd_data_r;
    assign ram_dout   = wdata_r;

endmodule

// File: tb/tb_pi_bus_ctl.sv
// Directed self-checking bench for pi_bus_ctl with a 16-phase frame generator and a RAM model.
module tb_pi_bus_ctl;

    localparam int AW = 17;
    localparam int DW = 8;

    logic          clk16 = 1'b0;
    logic          reset_n;
    logic          pi_select, pi_strobe, cpu_select, cpu_strobe;
    logic          pi_req, pi_we;
    logic [AW-1:0] pi_addr;
    logic [DW-1:0] pi_wr_data;
    logic          pi_busy, pi_done, pi_err;
    logic [DW-1:0] pi_rd_data;
    logic [AW-1:0] cpu_addr;
    logic          cpu_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic          ram_dout_oe, ram_we_n, ram_oe_n;

    int  checks = 0;
    int  errors = 0;
    int  phase;
    bit  strobe_en = 1'b1;
    bit  cpu_en = 1'b0;
    int  early_k;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    pi_bus_ctl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(40)) dut (
        .clk16(clk16), .reset_n(reset_n),
        .pi_select(pi_select), .pi_strobe(pi_strobe),
        .cpu_select(cpu_select), .cpu_strobe(cpu_strobe),
        .pi_req(pi_req), .pi_we(pi_we), .pi_addr(pi_addr), .pi_wr_data(pi_wr_data),
        .pi_busy(pi_busy), .pi_done(pi_done), .pi_err(pi_err), .pi_rd_data(pi_rd_data),
        .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_dout_oe(ram_dout_oe), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n)
    );

    always #5 clk16 = ~clk16;

    assign ram_din = mem[ram_addr];

    always @(posedge clk16) begin
        if (!ram_we_n && ram_dout_oe) mem[ram_addr] <= ram_dout;
    end

    // Frame: CPU window phases 0-3 (strobe 1-2), Pi window 8-11 (strobe 9-10)
    initial begin
        phase = 15;
        pi_select = 1'b0; pi_strobe = 1'b0; cpu_select = 1'b0; cpu_strobe = 1'b0;
        forever begin
            @(posedge clk16); #1;
            phase      = (phase + 1) % 16;
            pi_select  = (phase >= 8 && phase <= 11);
            pi_strobe  = strobe_en && (phase == 9 || phase == 10);
            cpu_select = (phase <= 3);
            cpu_strobe = cpu_en && (phase == 1 || phase == 2);
        end
    end

    task automatic wait_phase(input int p);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk16);
            if (phase == p) break;
        end
    endtask

    task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int start, input int ncyc,
                          output int we_low, output int oe_low, output int done_cnt, output int err_cnt,
                          output int done_k, output int err_k, output logic busy_at_ev,
                          output logic [AW-1:0] waddr, output logic [DW-1:0] wdata,
                          output logic [DW-1:0] rdata);
        bit seen_busy = 1'b0;
        we_low = 0; oe_low = 0; done_cnt = 0; err_cnt = 0; done_k = -1; err_k = -1;
        busy_at_ev = 1'bx; waddr = 'x; wdata = 'x; rdata = 'x;
        wait_phase(start - 1);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk16); #1;
            if (k == 0) begin
                pi_req = 1'b1; pi_we = we; pi_addr = addr; pi_wr_data = data;
            end else if (seen_busy) begin
                pi_req = 1'b0;
            end
            @(negedge clk16);
            if (pi_busy) seen_busy = 1'b1;
            if (!ram_we_n && ram_dout_oe) begin
                we_low++; waddr = ram_addr; wdata = ram_dout;
            end
            if (!ram_oe_n && pi_select) oe_low++;
            if (pi_done) begin
                done_cnt++;
                if (done_k < 0) begin done_k = k; busy_at_ev = pi_busy; rdata = pi_rd_data; end
            end
            if (pi_err) begin
                err_cnt++;
                if (err_k < 0) begin err_k = k; busy_at_ev = pi_busy; end
            end
        end
        pi_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk16);
        @(negedge clk16);
        checks++; if (pi_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", pi_busy); end
        checks++; if (pi_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", pi_done); end
        checks++; if (pi_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", pi_err); end
        checks++; if (pi_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", pi_rd_data); end
        checks++; if ({ram_we_n, ram_oe_n, ram_dout_oe} !== 3'b110) begin errors++; $display("FAIL reset_strobes: got %b expected 110", {ram_we_n, ram_oe_n, ram_dout_oe}); end
        @(posedge clk16); #1;
        reset_n = 1'b1;
        cpu_en = 1'b1;
    endtask

    task automatic test_write();
        int wl, ol, dc, ec, dk, ek; logic b; logic [AW-1:0] wa; logic [DW-1:0] wd, rd;
        do_txn(1'b1, 17'h08000, 8'hA5, 4, 24, wl, ol, dc, ec, dk, ek, b, wa, wd, rd);
        early_k = 4 + dk;
        checks++; if (wl !== 2) begin errors++; $display("FAIL write_we_cycles: got %0d expected 2", wl); end
        checks++; if (wa !== 17'h08000) begin errors++; $display("FAIL write_addr: got %h expected 08000", wa); end
        checks++; if (wd !== 8'hA5) begin errors++; $display("FAIL write_data: got %h expected a5", wd); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL write_done_count: got %0d expected 1", dc); end
        checks++; if (dk !== 8) begin errors++; $display("FAIL write_done_cycle: got %0d expected 8", dk); end
        checks++; if (b !== 1'b0) begin errors++; $display("FAIL write_busy_at_done: got %b expected 0", b); end
        checks++; if (ec !== 0) begin errors++; $display("FAIL write_no_err: got %0d expected 0", ec); end
    endtask

    task automatic test_cpu_slot();
        wait_phase(0);
        @(posedge clk16); #1;
        cpu_rw = 1'b0; cpu_addr = 17'h12345;
        @(negedge clk16);
        checks++; if ({ram_we_n, ram_oe_n, ram_dout_oe} !== 3'b010) begin errors++; $display("FAIL cpu_write_strobes: got %b expected 010", {ram_we_n, ram_oe_n, ram_dout_oe}); end
        checks++; if (ram_addr !== 17'h12345) begin errors++; $display("FAIL cpu_addr_mux: got %h expected 12345", ram_addr); end
        @(posedge clk16); #1;
        cpu_rw = 1'b1;
        @(negedge clk16);
        checks++; if ({ram_we_n, ram_oe_n, ram_dout_oe} !== 3'b100) begin errors++; $display("FAIL cpu_read_strobes: got %b expected 100", {ram_we_n, ram_oe_n, ram_dout_oe}); end
        wait_phase(8);
        checks++; if (ram_addr !== 17'h08000) begin errors++; $display("FAIL pi_addr_mux: got %h expected 08000", ram_addr); end
    endtask

    task automatic test_read();
        int wl, ol, dc, ec, dk, ek; logic b; logic [AW-1:0] wa; logic [DW-1:0] wd, rd;
        do_txn(1'b0, 17'h08000, 8'h00, 4, 24, wl, ol, dc, ec, dk, ek, b, wa, wd, rd);
        checks++; if (ol !== 2) begin errors++; $display("FAIL read_oe_cycles: got %0d expected 2", ol); end
        checks++; if (wl !== 0) begin errors++; $display("FAIL read_no_we: got %0d expected 0", wl); end
        checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL read_data: got %h expected a5", rd); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL read_done_count: got %0d expected 1", dc); end
    endtask

    task automatic test_late_request();
        int wl, ol, dc, ec, dk, ek; logic b; logic [AW-1:0] wa; logic [DW-1:0] wd, rd;
        do_txn(1'b1, 17'h04000, 8'h5C, 9, 40, wl, ol, dc, ec, dk, ek, b, wa, wd, rd);
        checks++; if ((9 + dk) - early_k !== 16) begin errors++; $display("FAIL late_done_delay: got %0d expected 16", (9 + dk) - early_k); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL late_done_count: got %0d expected 1", dc); end
        checks++; if (wa !== 17'h04000) begin errors++; $display("FAIL late_addr: got %h expected 04000", wa); end
    endtask

    task automatic test_timeout();
        int wl, ol, dc, ec, dk, ek; logic b; logic [AW-1:0] wa; logic [DW-1:0] wd, rd;
        strobe_en = 1'b0; cpu_en = 1'b0;
        do_txn(1'b1, 17'h00055, 8'h99, 4, 48, wl, ol, dc, ec, dk, ek, b, wa, wd, rd);
        checks++; if (ek !== 41) begin errors++; $display("FAIL timeout_cycle: got %0d expected 41", ek); end
        checks++; if (ec !== 1) begin errors++; $display("FAIL timeout_err_count: got %0d expected 1", ec); end
        checks++; if (b !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", b); end
        checks++; if (dc !== 0) begin errors++; $display("FAIL timeout_no_done: got %0d expected 0", dc); end
        checks++; if (wl + ol !== 0) begin errors++; $display("FAIL timeout_no_strobes: got %0d expected 0", wl + ol); end
        strobe_en = 1'b1; cpu_en = 1'b1;
    endtask

    task automatic test_mid_reset();
        int wl, ol, dc, ec, dk, ek; logic b; logic [AW-1:0] wa; logic [DW-1:0] wd, rd;
        int dseen = 0;
        wait_phase(3);
        @(posedge clk16); #1;
        pi_req = 1'b1; pi_we = 1'b1; pi_addr = 17'h00100; pi_wr_data = 8'h5A;
        @(posedge clk16); #1;
        pi_req = 1'b0;
        wait_phase(9);
        checks++; if (ram_we_n !== 1'b0) begin errors++; $display("FAIL midrst_in_access: got %b expected 0", ram_we_n); end
        @(posedge clk16); #1;
        reset_n = 1'b0;
        @(posedge clk16); #1;
        reset_n = 1'b1;
        @(negedge clk16);
        checks++; if (pi_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", pi_busy); end
        checks++; if ({ram_we_n, ram_oe_n, ram_dout_oe} !== 3'b110) begin errors++; $display("FAIL midrst_strobes: got %b expected 110", {ram_we_n, ram_oe_n, ram_dout_oe}); end
        for (int i = 0; i < 20; i++) begin
            if (pi_done || pi_err) dseen++;
            @(negedge clk16);
        end
        checks++; if (dseen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", dseen); end
        do_txn(1'b1, 17'h00200, 8'h3C, 4, 24, wl, ol, dc, ec, dk, ek, b, wa, wd, rd);
        checks++; if (dc !== 1 || wl !== 2) begin errors++; $display("FAIL midrst_recover: got done=%0d we=%0d expected done=1 we=2", dc, wl); end
        checks++; if (wa !== 17'h00200) begin errors++; $display("FAIL midrst_recover_addr: got %h expected 00200", wa); end
    endtask

    task automatic test_back_to_back();
        int dcnt = 0; int d0 = -1; int d1 = -1;
        logic busy9, busy25;
        busy9 = 1'bx; busy25 = 1'bx;
        wait_phase(3);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk16); #1;
            if (k == 0) begin
                pi_req = 1'b1; pi_we = 1'b1; pi_addr = 17'h00300; pi_wr_data = 8'h77;
            end else if (k == 24) begin
                pi_req = 1'b0;
            end
            @(negedge clk16);
            if (pi_done) begin
                dcnt++;
                if (d0 < 0) d0 = k; else if (d1 < 0) d1 = k;
            end
            if (k == 9) busy9 = pi_busy;
            if (k == 25) busy25 = pi_busy;
        end
        checks++; if (dcnt !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", dcnt); end
        checks++; if (d0 !== 8 || d1 !== 24) begin errors++; $display("FAIL b2b_done_cycles: got %0d,%0d expected 8,24", d0, d1); end
        checks++; if (busy9 !== 1'b1) begin errors++; $display("FAIL b2b_relatch: got %b expected 1", busy9); end
        checks++; if (busy25 !== 1'b0) begin errors++; $display("FAIL b2b_release: got %b expected 0", busy25); end
    endtask

    task automatic test_burst();
        int wl, ol, dc, ec, dk, ek; logic b; logic [AW-1:0] wa; logic [DW-1:0] wd, rd;
        logic [AW-1:0] exp2, exp3;
`ifdef PI_ADDR_INC_EN
        exp2 = 17'h1FFFF; exp3 = 17'h00000;
`else
        exp2 = 17'h1FFFF; exp3 = 17'h1FFFF;
`endif
        do_txn(1'b1, 17'h1FFFE, 8'h10, 4, 24, wl, ol, dc, ec, dk, ek, b, wa, wd, rd);
        checks++; if (wa !== 17'h1FFFE) begin errors++; $display("FAIL burst_first_addr: got %h expected 1fffe", wa); end
        do_txn(1'b1, 17'h1FFFF, 8'h11, 4, 24, wl, ol, dc, ec, dk, ek, b, wa, wd, rd);
        checks++; if (wa !== exp2) begin errors++; $display("FAIL burst_second_addr: got %h expected %h", wa, exp2); end
        checks++; if (wd !== 8'h11) begin errors++; $display("FAIL burst_second_data: got %h expected 11", wd); end
        do_txn(1'b1, 17'h1FFFF, 8'h22, 4, 24, wl, ol, dc, ec, dk, ek, b, wa, wd, rd);
        checks++; if (wa !== exp3) begin errors++; $display("FAIL burst_wrap_addr: got %h expected %h", wa, exp3); end
        checks++; if (wd !== 8'h22 || dc !== 1) begin errors++; $display("FAIL burst_wrap_data: got %h/%0d expected 22/1", wd, dc); end
    endtask

    initial begin
        reset_n = 1'b0; pi_req = 1'b0; pi_we = 1'b0; pi_addr = '0; pi_wr_data = '0;
        cpu_addr = '0; cpu_rw = 1'b1;
        early_k = 0;
        test_reset();
        test_write();
        test_cpu_slot();
        test_read();
        test_late_request();
        test_timeout();
        test_mid_reset();
        test_back_to_back();
        test_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
